// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Two-master / one-slave arbiter for the native memory bus with
//             round-robin or fixed priority and a slave timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int          FAIR      = 1,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_TO_MAX = CW'(TIMEOUT);
  localparam bit            C_TO_EN  = (TIMEOUT > 0);
  localparam bit            C_FAIR   = (FAIR != 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_grant;
  logic          r_last;
  logic [CW-1:0] r_cnt;

  logic w_req;
  logic w_arb;
  logic w_busy;
  logic w_gvalid;
  logic w_to;
  logic w_done;

  // Shared decode of the in-flight transaction
  always_comb begin
    w_req    = m0_valid || m1_valid;
    w_busy   = (r_state == S_BUSY);
    w_gvalid = r_grant ? m1_valid : m0_valid;
    w_to     = C_TO_EN && w_busy && w_gvalid && !s_ready && (r_cnt == C_TO_MAX);
    w_done   = w_busy && w_gvalid && (s_ready || w_to);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (m0_valid && m1_valid) begin
      w_arb = C_FAIR ? ~r_last : 1'b0;
    end else begin
      w_arb = m1_valid;
    end
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_BUSY;
      // A granted master dropping valid aborts the transaction silently
      S_BUSY:  if (!w_gvalid || w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant/pointer capture and the saturating stall counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_grant <= w_arb;
      r_last  <= w_arb;
      r_cnt   <= '0;
    end else if (w_busy && !s_ready && r_cnt != C_TO_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    busy        = 1'b0;
    grant       = 1'b0;
    timeout_err = 1'b0;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    if (w_busy) begin
      busy        = 1'b1;
      grant       = r_grant;
      timeout_err = w_to;
      s_valid     = w_gvalid && !w_to;
      if (r_grant) begin
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = w_done;
        m1_rdata = w_to ? ERR_RDATA : s_rdata;
      end else begin
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = w_done;
        m0_rdata = w_to ? ERR_RDATA : s_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Scoreboard bench running a round-robin and a fixed-priority
//             arbiter side by side on identical master stimulus.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        a_m0_ready, a_m1_ready, a_s_valid, a_s_ready, a_grant, a_busy, a_to;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
  logic [3:0]  a_s_wstrb;
  logic        b_m0_ready, b_m1_ready, b_s_valid, b_s_ready, b_grant, b_busy, b_to;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic [3:0]  b_s_wstrb;

  logic sl_en;
  int   sl_lat;
  int   a_wcnt = 0;
  int   b_wcnt = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.FAIR(1), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut_a (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(a_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(a_m1_rdata),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_wstrb(a_s_wstrb), .s_rdata(s_rdata),
    .grant(a_grant), .busy(a_busy), .timeout_err(a_to)
  );

  mem_bus_arbiter #(.FAIR(0), .TIMEOUT(4), .ERR_RDATA(32'hDEADBEEF)) dut_b (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(b_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(b_m1_rdata),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_wstrb(b_s_wstrb), .s_rdata(s_rdata),
    .grant(b_grant), .busy(b_busy), .timeout_err(b_to)
  );

  // Slave model: answers sl_lat cycles after the transaction starts
  assign a_s_ready = sl_en && a_busy && (a_wcnt == sl_lat);
  assign b_s_ready = sl_en && b_busy && (b_wcnt == sl_lat);

  always @(posedge clk) begin
    a_wcnt <= (a_busy && !a_s_ready) ? a_wcnt + 1 : 0;
    b_wcnt <= (b_busy && !b_s_ready) ? b_wcnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic idx, input logic [31:0] d, input logic err);
    qa.push_back('{idx: idx, rdata: d, err: err});
    qb.push_back('{idx: idx, rdata: d, err: err});
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(a_m0_ready || a_m1_ready) && cnt < 20);
    chk("ready_seen", {31'b0, a_m0_ready | a_m1_ready}, 32'd1);
  endtask

  // Scoreboard: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (a_m0_ready || a_m1_ready) begin
      chk("a_both_ready", {31'b0, a_m0_ready & a_m1_ready}, 32'd0);
      if (qa.size() == 0) begin
        chk("a_unexpected_ready", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_idx", {31'b0, a_m1_ready}, {31'b0, ea.idx});
        chk("a_rdata", a_m1_ready ? a_m1_rdata : a_m0_rdata, ea.rdata);
        chk("a_err", {31'b0, a_to}, {31'b0, ea.err});
      end
    end else if (a_to) begin
      chk("a_err_no_ready", {31'b0, a_to}, 32'd0);
    end
    if (b_m0_ready || b_m1_ready) begin
      chk("b_both_ready", {31'b0, b_m0_ready & b_m1_ready}, 32'd0);
      if (qb.size() == 0) begin
        chk("b_unexpected_ready", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_idx", {31'b0, b_m1_ready}, {31'b0, eb.idx});
        chk("b_rdata", b_m1_ready ? b_m1_rdata : b_m0_rdata, eb.rdata);
        chk("b_err", {31'b0, b_to}, {31'b0, eb.err});
      end
    end else if (b_to) begin
      chk("b_err_no_ready", {31'b0, b_to}, 32'd0);
    end
  end

  initial begin
    reset    = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata  = '0;
    sl_en    = 1'b1;
    sl_lat   = 1;
    step();
    step();
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_grant", {31'b0, a_grant}, 32'd0);
    chk("rst_svalid", {31'b0, a_s_valid}, 32'd0);
    chk("rst_to", {31'b0, a_to}, 32'd0);
    chk("rst_saddr", a_s_addr, 32'd0);
    reset = 1'b1;

    // Single CPU read, slave answers on the third BUSY cycle
    sl_lat  = 2;
    s_rdata = 32'h12345678;
    push_both(1'b0, 32'h12345678, 1'b0);
    m0_valid = 1'b1; m0_addr = 32'h0002_0000; m0_wstrb = 4'b0000;
    step();
    chk("rd_svalid", {31'b0, a_s_valid}, 32'd1);
    chk("rd_saddr", a_s_addr, 32'h0002_0000);
    chk("rd_grant", {31'b0, a_grant}, 32'd0);
    wait_done(n);
    chk("rd_lat", 32'(n), 32'd2);
    step();
    m0_valid = 1'b0;

    // Tie: FAIR=1 alternates from m0, FAIR=0 always picks m0
    reset = 1'b0;
    step();
    reset   = 1'b1;
    sl_lat  = 1;
    s_rdata = 32'h1111_0000;
    for (int i = 0; i < 4; i++) begin
      qa.push_back('{idx: i[0], rdata: 32'h1111_0000, err: 1'b0});
      qb.push_back('{idx: 1'b0, rdata: 32'h1111_0000, err: 1'b0});
    end
    m0_valid = 1'b1; m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      chk("tie_lat", 32'(n), 32'd2);
      step();
      chk("tie_idle_gap", {31'b0, a_busy}, 32'd0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;

    // m1 write held stable while m0 requests mid-transaction
    sl_lat  = 3;
    s_rdata = 32'h0BAD_F00D;
    push_both(1'b1, 32'h0BAD_F00D, 1'b0);
    push_both(1'b0, 32'h0BAD_F00D, 1'b0);
    m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
    step();
    chk("wr_grant", {31'b0, a_grant}, 32'd1);
    m0_valid = 1'b1; m0_addr = 32'h0002_0004; m0_wstrb = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr_saddr", a_s_addr, 32'h0000_0100);
      chk("wr_swdata", a_s_wdata, 32'hA5A5_A5A5);
      chk("wr_swstrb", {28'b0, a_s_wstrb}, 32'd3);
      chk("wr_m0_blocked", {31'b0, a_m0_ready}, 32'd0);
      chk("wr_m0_rdata0", a_m0_rdata, 32'd0);
    end
    chk("wr_m1_ready", {31'b0, a_m1_ready}, 32'd1);
    step();
    m1_valid = 1'b0;
    chk("wr_idle_gap", {31'b0, a_busy}, 32'd0);
    step();
    chk("wr_m0_grant", {31'b0, a_grant}, 32'd0);
    chk("wr_m0_saddr", a_s_addr, 32'h0002_0004);
    wait_done(n);
    chk("wr_m0_lat", 32'(n), 32'd3);
    step();
    m0_valid = 1'b0;

    // Dead slave: forced completion on the fifth BUSY cycle
    sl_en = 1'b0;
    push_both(1'b0, 32'hDEADBEEF, 1'b1);
    m0_valid = 1'b1; m0_addr = 32'h0002_0008;
    wait_done(n);
    chk("to_cycle", 32'(n), 32'd5);
    chk("to_flag", {31'b0, a_to}, 32'd1);
    chk("to_svalid", {31'b0, a_s_valid}, 32'd0);
    step();
    chk("to_idle", {31'b0, a_busy}, 32'd0);
    m0_valid = 1'b0;

    // Slave answers exactly at the timeout boundary
    sl_en   = 1'b1;
    sl_lat  = 4;
    s_rdata = 32'hCAFE_F00D;
    push_both(1'b0, 32'hCAFE_F00D, 1'b0);
    m0_valid = 1'b1;
    wait_done(n);
    chk("edge_cycle", 32'(n), 32'd5);
    chk("edge_flag", {31'b0, a_to}, 32'd0);
    step();
    m0_valid = 1'b0;

    // Reset mid-transaction aborts, then the next tie goes to m0
    sl_en = 1'b0;
    m0_valid = 1'b1;
    step();
    step();
    chk("ab_busy_before", {31'b0, a_busy}, 32'd1);
    reset = 1'b0;
    step();
    chk("ab_busy", {31'b0, a_busy}, 32'd0);
    chk("ab_svalid", {31'b0, a_s_valid}, 32'd0);
    chk("ab_ready", {31'b0, a_m0_ready}, 32'd0);
    reset    = 1'b1;
    sl_en    = 1'b1;
    sl_lat   = 1;
    s_rdata  = 32'h0000_5A5A;
    push_both(1'b0, 32'h0000_5A5A, 1'b0);
    m1_valid = 1'b1;
    step();
    chk("ab_tie_grant_a", {31'b0, a_grant}, 32'd0);
    chk("ab_tie_grant_b", {31'b0, b_grant}, 32'd0);
    wait_done(n);
    step();
    m0_valid = 1'b0; m1_valid = 1'b0;

    step();
    step();
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
